legv8_register_file: RTL
========================

# legv8_register_file

LEGv8 register file (X0–X30 plus hard-wired XZR) fed by the Reg2Loc 5-bit read-address mux and the instruction's Rn field, consumed by the ALU operand stage. Two combinational read ports and one clocked write port. After reset, a single-write-port clear sequencer zeroes the array one register per cycle, so the storage maps onto RAM-style arrays. `Ready` gates the core until the array is clean.

## Interface
- DATA_WIDTH, 64, register and data-port width in bits
- CLK  input  1  rising-edge clock
- Reset_n  input  1  synchronous, active-low reset
- ReadReg1  input  5  read port 1 address (instruction bits 9:5)
- ReadReg2  input  5  read port 2 address (Reg2Loc mux output)
- WriteReg  input  5  write address (instruction bits 4:0)
- WriteData  input  DATA_WIDTH  write data
- RegWrite  input  1  write enable
- ReadData1  output  DATA_WIDTH  port 1 read data, combinational
- ReadData2  output  DATA_WIDTH  port 2 read data, combinational
- Ready  output  1  high once the clear sequence completes; registered

## Operation
- Storage: 31 entries, `regs[0..30]`, each DATA_WIDTH bits. Address 31 is XZR.
  - XZR always reads 0.
  - Writes to address 31 are discarded.
- States:
  - CLEAR: clear pointer `clr_ptr` (5 bits) active, `Ready`=0.
  - RUN: `Ready`=1.
- Reset (Reset_n sampled low at a rising edge):
  - Next state is CLEAR, `clr_ptr`=0, `Ready`=0.
  - No array write occurs on that edge.
  - Array contents are not reset directly.
- CLEAR with Reset_n high:
  - Each edge writes 0 to `regs[clr_ptr]` and increments `clr_ptr`.
  - The edge that writes `regs[30]` transitions to RUN and sets `Ready`=1.
- RUN: on each edge with RegWrite=1 and WriteReg≠31, `regs[WriteReg]` ← WriteData.
- RegWrite during CLEAR is ignored. The write is dropped, not queued; upstream must hold off until `Ready`=1.
- Reads:
  - ReadDataN = 0 if ReadRegN==31 or state is CLEAR.
  - Otherwise ReadDataN = `regs[ReadRegN]`, subject to the bypass described under Configuration.
- Both read ports may address the same register, including the write target; each port resolves independently.
- Reset mid-CLEAR restarts the sequence with `clr_ptr`=0. Reset in RUN returns to CLEAR.
- No arithmetic beyond the 5-bit `clr_ptr` increment, which terminates at 30 and never wraps.

## Timing
- Reset values: `Ready`=0, ReadData1=ReadData2=0 (forced during CLEAR).
- Clear latency: exactly 31 rising edges with Reset_n high after the reset edge. `Ready` rises after the 31st edge.
- Write latency: 1 edge. Data written at edge N is visible on the read ports from just after edge N.
- Read latency: 0. The read ports are purely combinational from the ReadReg inputs and array state.
- Simultaneous read and write of the same register in one cycle:
  - The read returns the pre-write value.
  - Exception: when the bypass is compiled in, the read returns WriteData (see Configuration).

## Configuration
- Macro: `REGFILE_WRITE_BYPASS_EN`.
- Defined:
  - Applies in RUN, when RegWrite=1, WriteReg≠31 and WriteReg==ReadRegN.
  - ReadDataN = WriteData combinationally in that same cycle (write-through forwarding for a pipelined core).
  - Per port, and independent on each port.
- Undefined: no forwarding. The read returns the stored value until the edge commits the write.
- XZR and CLEAR zero-forcing take priority over the bypass in both builds.

## Test plan
- Reset and clear:
  - Preload the array via writes.
  - Hold Reset_n low for 3 edges, then release.
  - Required: `Ready`=0 for exactly 31 edges, then 1.
  - Required: all reads of 0–31 return 0; ReadData stays 0 throughout CLEAR.
- Write/read:
  - In RUN, write X5=64'hDEAD_BEEF_0123_4567.
  - Next cycle ReadReg1=5, ReadReg2=5. Required: both ports read 64'hDEAD_BEEF_0123_4567.
- XZR:
  - Write 64'hFFFF_FFFF_FFFF_FFFF to register 31.
  - Required: ReadReg2=31 reads 0, and X0–X30 are unchanged.
- Mid-CLEAR reset:
  - Assert Reset_n low at clear edge 10, then release.
  - Required: `Ready` rises 31 edges after the release, not 21.
- Write during CLEAR:
  - Issue RegWrite=1, WriteReg=3, WriteData=64'h1 on clear edge 20 (after X3 has been cleared).
  - Required: X3 reads 0 once `Ready`=1.
- Same-cycle read of the write target:
  - RegWrite=1, WriteReg=7, WriteData=64'hA5, ReadReg1=7, with X7 previously 64'h11.
  - Required: ReadData1=64'hA5 when `REGFILE_WRITE_BYPASS_EN` is defined, 64'h11 when it is not.
  - Required in both builds: 64'hA5 after the edge.

Source files
------------

// File: rtl/legv8_register_file.sv
// LEGv8 register file: X0-X30 plus XZR, two async read ports, one write port.
// Optional write-through read forwarding: REGFILE_WRITE_BYPASS_EN.
module legv8_register_file #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic [4:0]            ReadReg1,
  input  logic [4:0]            ReadReg2,
  input  logic [4:0]            WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  Ready
);

  localparam logic [4:0] XZR  = 5'd31;
  localparam logic [4:0] LAST = 5'd30;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t                state;
  logic [4:0]            clr_ptr;
  logic [DATA_WIDTH-1:0] regs [0:30];

  logic                  we;
  logic [4:0]            waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  byp1;
  logic                  byp2;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      Ready   <= 1'b0;
    end else if (state == CLEAR) begin
      if (clr_ptr == LAST) begin
        state <= RUN;
        Ready <= 1'b1;
      end else begin
        clr_ptr <= clr_ptr + 5'd1;
      end
    end
  end

  // One shared write port: the clear sequencer owns it until RUN.
  always_comb begin
    we    = 1'b0;
    waddr = clr_ptr;
    wdata = '0;
    if (Reset_n) begin
      if (state == CLEAR) begin
        we = 1'b1;
      end else if (RegWrite && WriteReg != XZR) begin
        we    = 1'b1;
        waddr = WriteReg;
        wdata = WriteData;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (we) begin
      regs[waddr] <= wdata;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  assign byp1 = RegWrite && WriteReg != XZR && WriteReg == ReadReg1;
  assign byp2 = RegWrite && WriteReg != XZR && WriteReg == ReadReg2;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Zero forcing outranks forwarding.
  assign ReadData1 = (ReadReg1 == XZR || state != RUN) ? '0 :
                     byp1 ? WriteData : regs[ReadReg1];
  assign ReadData2 = (ReadReg2 == XZR || state != RUN) ? '0 :
                     byp2 ? WriteData : regs[ReadReg2];

endmodule
